// File: rtl/load_writeback.sv
// Retire-stage register writeback with load data extraction and alignment checks.
// Optional macro LOAD_WB_FWD_EN adds fwd_* ports showing next cycle's write.
module load_writeback #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   localparam int OFF_W     = $clog2(DATA_W / 8)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_rd_valid,
   input  logic [REG_ADDR_W-1:0] in_rd_addr,
   input  logic [DATA_W-1:0]     in_alu_value,
   input  logic                  in_is_load,
   input  logic [1:0]            in_ld_size,
   input  logic                  in_ld_unsigned,
   input  logic [OFF_W-1:0]      in_addr_lo,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_W-1:0]     mem_rsp_data,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0]     wr_value,
   output logic                  stall,
   output logic                  misalign
`ifdef LOAD_WB_FWD_EN
   ,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0]     fwd_value
`endif
);

   typedef enum logic {
      IDLE,
      WAIT_RSP
   } state_t;

   state_t                r_state;
   logic                  r_rd_valid;
   logic [REG_ADDR_W-1:0] r_rd_addr;
   logic [1:0]            r_size;
   logic                  r_uns;
   logic [OFF_W-1:0]      r_off;

   logic                  w_idle;
   logic                  w_acc;
   logic                  w_ld_done;
   logic                  w_f_rd_valid;
   logic [REG_ADDR_W-1:0] w_f_rd_addr;
   logic [1:0]            w_f_size;
   logic                  w_f_uns;
   logic [OFF_W-1:0]      w_f_off;
   logic [DATA_W-1:0]     w_ext;
   logic                  w_mis;
   logic                  w_nx_we;
   logic                  w_nx_mis;
   logic [REG_ADDR_W-1:0] w_nx_addr;
   logic [DATA_W-1:0]     w_nx_val;

   // A 32-bit datapath has no dword, so size 3 folds onto word.
   function automatic logic [1:0] f_eff_size(input logic [1:0] sz);
      logic [1:0] o;
      o = sz;
      if (DATA_W == 32 && sz == 2'd3) o = 2'd2;
      return o;
   endfunction

   function automatic logic f_misal(
      input logic [1:0]       sz,
      input logic [OFF_W-1:0] off
   );
      logic m;
      case (sz)
         2'd0:    m = 1'b0;
         2'd1:    m = off[0];
         2'd2:    m = (off[1:0] != 2'b00);
         default: m = (off != '0);
      endcase
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] f_extract(
      input logic [DATA_W-1:0] data,
      input logic [1:0]        sz,
      input logic              uns,
      input logic [OFF_W-1:0]  off
   );
      logic [OFF_W-1:0]  a;
      logic [DATA_W-1:0] r;
      logic [DATA_W-1:0] o;
      logic              s;
      int                n;
      a = off;
      case (sz)
         2'd0:    a = off;
         2'd1:    a[0] = 1'b0;
         2'd2:    a[1:0] = 2'b00;
         default: a = '0;
      endcase
      r = data >> {a, 3'b000};
      case (sz)
         2'd0: begin
            s = r[7];
            n = 8;
         end
         2'd1: begin
            s = r[15];
            n = 16;
         end
         2'd2: begin
            s = r[31];
            n = 32;
         end
         default: begin
            s = r[DATA_W-1];
            n = DATA_W;
         end
      endcase
      s = s & ~uns;
      for (int i = 0; i < DATA_W; i++) begin
         o[i] = (i < n) ? r[i] : s;
      end
      return o;
   endfunction

   assign w_idle    = (r_state == IDLE);
   assign w_acc     = in_valid && w_idle;
   assign in_ready  = w_idle;
   assign stall     = !w_idle;
   assign w_ld_done = mem_rsp_valid && (!w_idle || (w_acc && in_is_load));

   // While waiting, the latched request describes the response, not the inputs.
   assign w_f_rd_valid = w_idle ? in_rd_valid : r_rd_valid;
   assign w_f_rd_addr  = w_idle ? in_rd_addr : r_rd_addr;
   assign w_f_size     = w_idle ? f_eff_size(in_ld_size) : r_size;
   assign w_f_uns      = w_idle ? in_ld_unsigned : r_uns;
   assign w_f_off      = w_idle ? in_addr_lo : r_off;

   assign w_ext = f_extract(mem_rsp_data, w_f_size, w_f_uns, w_f_off);
   assign w_mis = f_misal(w_f_size, w_f_off);

   always_comb begin
      w_nx_we   = 1'b0;
      w_nx_mis  = 1'b0;
      w_nx_addr = w_f_rd_addr;
      w_nx_val  = w_ext;
      if (rst) begin
         w_nx_we  = 1'b0;
         w_nx_mis = 1'b0;
      end else if (w_acc && !in_is_load) begin
         w_nx_we  = in_rd_valid && (in_rd_addr != '0);
         w_nx_val = in_alu_value;
      end else if (w_ld_done) begin
         w_nx_we  = w_f_rd_valid && (w_f_rd_addr != '0) && !w_mis;
         w_nx_mis = w_mis;
      end
   end

`ifdef LOAD_WB_FWD_EN
   assign fwd_valid = w_nx_we;
   assign fwd_addr  = w_nx_addr;
   assign fwd_value = w_nx_val;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         wr_en      <= 1'b0;
         misalign   <= 1'b0;
         wr_addr    <= '0;
         wr_value   <= '0;
         r_rd_valid <= 1'b0;
         r_rd_addr  <= '0;
         r_size     <= 2'd0;
         r_uns      <= 1'b0;
         r_off      <= '0;
      end else begin
         wr_en    <= w_nx_we;
         misalign <= w_nx_mis;
         if (w_nx_we) begin
            wr_addr  <= w_nx_addr;
            wr_value <= w_nx_val;
         end
         case (r_state)
            IDLE: begin
               if (w_acc && in_is_load && !mem_rsp_valid) begin
                  r_rd_valid <= in_rd_valid;
                  r_rd_addr  <= in_rd_addr;
                  r_size     <= f_eff_size(in_ld_size);
                  r_uns      <= in_ld_unsigned;
                  r_off      <= in_addr_lo;
                  r_state    <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (mem_rsp_valid) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_writeback.sv
// Directed bench for load_writeback: 32-bit scoreboard plus 64-bit spot checks.
// Define LOAD_WB_FWD_EN to also check the bypass ports.
module tb_load_writeback;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] val;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_rd_valid, in_is_load, in_ld_unsigned;
   logic [4:0]  in_rd_addr;
   logic [31:0] in_alu_value, mem_rsp_data, wr_value;
   logic [1:0]  in_ld_size, in_addr_lo;
   logic        mem_rsp_valid, wr_en, stall, misalign;
   logic [4:0]  wr_addr;

   logic        d_in_valid, d_in_ready, d_in_rd_valid, d_in_is_load, d_in_uns;
   logic [4:0]  d_in_rd_addr, d_wr_addr;
   logic [63:0] d_in_alu, d_rsp_data, d_wr_value;
   logic [1:0]  d_in_size;
   logic [2:0]  d_in_off;
   logic        d_rsp_valid, d_wr_en, d_stall, d_misalign;

`ifdef LOAD_WB_FWD_EN
   logic        fwd_valid, d_fwd_valid;
   logic [4:0]  fwd_addr, d_fwd_addr;
   logic [31:0] fwd_value;
   logic [63:0] d_fwd_value;
`endif

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [4:0]  m_addr;
   logic [31:0] m_val;

   always #5 clk = ~clk;

   load_writeback #(.DATA_W(32), .REG_ADDR_W(5)) u_dut32 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rd_valid(in_rd_valid), .in_rd_addr(in_rd_addr),
      .in_alu_value(in_alu_value), .in_is_load(in_is_load),
      .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
      .in_addr_lo(in_addr_lo),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_value(wr_value),
      .stall(stall), .misalign(misalign)
`ifdef LOAD_WB_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_value(fwd_value)
`endif
   );

   load_writeback #(.DATA_W(64), .REG_ADDR_W(5)) u_dut64 (
      .clk(clk), .rst(rst),
      .in_valid(d_in_valid), .in_ready(d_in_ready),
      .in_rd_valid(d_in_rd_valid), .in_rd_addr(d_in_rd_addr),
      .in_alu_value(d_in_alu), .in_is_load(d_in_is_load),
      .in_ld_size(d_in_size), .in_ld_unsigned(d_in_uns),
      .in_addr_lo(d_in_off),
      .mem_rsp_valid(d_rsp_valid), .mem_rsp_data(d_rsp_data),
      .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_value(d_wr_value),
      .stall(d_stall), .misalign(d_misalign)
`ifdef LOAD_WB_FWD_EN
      , .fwd_valid(d_fwd_valid), .fwd_addr(d_fwd_addr), .fwd_value(d_fwd_value)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      in_valid = 0; in_rd_valid = 0; in_rd_addr = 0; in_alu_value = 0;
      in_is_load = 0; in_ld_size = 0; in_ld_unsigned = 0; in_addr_lo = 0;
      mem_rsp_valid = 0; mem_rsp_data = 0;
      d_in_valid = 0; d_in_rd_valid = 0; d_in_rd_addr = 0; d_in_alu = 0;
      d_in_is_load = 0; d_in_size = 0; d_in_uns = 0; d_in_off = 0;
      d_rsp_valid = 0; d_rsp_data = 0;
   endtask

   task automatic issue(input logic rv, input logic [4:0] rd, input logic [31:0] alu,
                        input logic ld, input logic [1:0] sz, input logic uns,
                        input logic [1:0] off, input logic rsp, input logic [31:0] data);
      in_valid = 1; in_rd_valid = rv; in_rd_addr = rd; in_alu_value = alu;
      in_is_load = ld; in_ld_size = sz; in_ld_unsigned = uns; in_addr_lo = off;
      mem_rsp_valid = rsp; mem_rsp_data = data;
   endtask

   task automatic push(input logic we, input logic [4:0] a, input logic [31:0] v,
                       input logic mis);
      exp_t e;
      e.we = we; e.addr = a; e.val = v; e.mis = mis;
      sb.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         if (e.we) begin
            m_addr = e.addr;
            m_val  = e.val;
         end
         chk({tag, ".wr_en"}, wr_en, e.we);
         chk({tag, ".misalign"}, misalign, e.mis);
         chk({tag, ".wr_addr"}, wr_addr, m_addr);
         chk({tag, ".wr_value"}, wr_value, m_val);
      end
   endtask

   // One-cycle transaction: drive, clock, compare against the popped result.
   task automatic one(input string tag, input logic rv, input logic [4:0] rd,
                      input logic [31:0] alu, input logic ld, input logic [1:0] sz,
                      input logic uns, input logic [1:0] off, input logic [31:0] data,
                      input logic we, input logic [31:0] v, input logic mis);
      issue(rv, rd, alu, ld, sz, uns, off, ld, data);
      push(we, rd, v, mis);
      step();
      clr();
      check_out(tag);
      chk({tag, ".ready"}, in_ready, 1'b1);
   endtask

   task automatic d_one(input string tag, input logic [1:0] sz, input logic uns,
                        input logic [2:0] off, input logic [63:0] data,
                        input logic we, input logic [63:0] v, input logic mis);
      d_in_valid = 1; d_in_rd_valid = 1; d_in_rd_addr = 5'd11; d_in_is_load = 1;
      d_in_size = sz; d_in_uns = uns; d_in_off = off;
      d_rsp_valid = 1; d_rsp_data = data;
      #1;
`ifdef LOAD_WB_FWD_EN
      chk({tag, ".fwd_valid"}, d_fwd_valid, we);
      if (we) chk({tag, ".fwd_value"}, d_fwd_value, v);
`endif
      step();
      clr();
      chk({tag, ".wr_en"}, d_wr_en, we);
      chk({tag, ".misalign"}, d_misalign, mis);
      if (we) chk({tag, ".wr_value"}, d_wr_value, v);
   endtask

   initial begin
      clr();
      rst = 1;
      m_addr = 0;
      m_val = 0;
      step();
      step();
      rst = 0;
      chk("rst.wr_en", wr_en, 0);
      chk("rst.misalign", misalign, 0);
      chk("rst.wr_addr", wr_addr, 0);
      chk("rst.wr_value", wr_value, 0);
      chk("rst.stall", stall, 0);
      chk("rst.ready", in_ready, 1);
      chk("rst64.ready", d_in_ready, 1);

      issue(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
      push(1, 5'd5, 32'h1234_5678, 0);
`ifdef LOAD_WB_FWD_EN
      #1;
      chk("alu.fwd_valid", fwd_valid, 1);
      chk("alu.fwd_value", fwd_value, 32'h1234_5678);
`endif
      step();
      clr();
      check_out("alu");
      push(0, 5'd0, 0, 0);
      step();
      check_out("alu.pulse");

      one("alu.x0", 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0);
      one("alu.norv", 0, 5'd7, 32'hCAFE_0001, 0, 0, 0, 0, 0, 0, 0, 0);
      one("lb", 1, 5'd3, 0, 1, 2'd0, 0, 2'd2, 32'h0080_0000, 1, 32'hFFFF_FF80, 0);
      one("lbu", 1, 5'd4, 0, 1, 2'd0, 1, 2'd2, 32'h0080_0000, 1, 32'h0000_0080, 0);
      one("lb.off1", 1, 5'd13, 0, 1, 2'd0, 0, 2'd1, 32'h0000_8100, 1, 32'hFFFF_FF81, 0);
      one("lb.off3", 1, 5'd14, 0, 1, 2'd0, 0, 2'd3, 32'h7F00_0000, 1, 32'h0000_007F, 0);
      one("lhu", 1, 5'd15, 0, 1, 2'd1, 1, 2'd0, 32'h1234_F00D, 1, 32'h0000_F00D, 0);
      one("ld.as.lw", 1, 5'd10, 0, 1, 2'd3, 0, 2'd0, 32'h89AB_CDEF, 1, 32'h89AB_CDEF, 0);
      one("lw.mis", 1, 5'd8, 0, 1, 2'd2, 0, 2'd1, 32'h1111_1111, 0, 0, 1);
      push(0, 5'd0, 0, 0);
      step();
      check_out("mis.pulse");
      one("lw.x0", 1, 5'd0, 0, 1, 2'd2, 0, 2'd0, 32'h2222_2222, 0, 0, 0);
      one("lh.x0.mis", 1, 5'd0, 0, 1, 2'd1, 0, 2'd1, 32'h3333_3333, 0, 0, 1);

      mem_rsp_valid = 1;
      mem_rsp_data = 32'h4444_4444;
      push(0, 5'd0, 0, 0);
      step();
      clr();
      check_out("stray.rsp");
      chk("stray.ready", in_ready, 1);

      issue(1, 5'd6, 0, 1, 2'd1, 0, 2'd2, 0, 0);
      step();
      // Competing load request during the wait must be ignored.
      issue(1, 5'd9, 32'h9999_9999, 1, 2'd0, 1, 2'd0, 0, 0);
      for (int c = 0; c < 2; c++) begin
         chk("lh.wait.stall", stall, 1);
         chk("lh.wait.ready", in_ready, 0);
         chk("lh.wait.wr_en", wr_en, 0);
         step();
      end
      chk("lh.wait3.stall", stall, 1);
      chk("lh.wait3.ready", in_ready, 0);
      mem_rsp_valid = 1;
      mem_rsp_data = 32'hBEEF_0000;
      push(1, 5'd6, 32'hFFFF_BEEF, 0);
      step();
      clr();
      check_out("lh.late");
      chk("lh.late.stall", stall, 0);
      chk("lh.late.ready", in_ready, 1);
      push(0, 5'd0, 0, 0);
      step();
      check_out("lh.late.after");

      issue(1, 5'd12, 0, 1, 2'd2, 0, 2'd0, 0, 0);
      step();
      clr();
      chk("rstw.stall", stall, 1);
      rst = 1;
      mem_rsp_valid = 1;
      mem_rsp_data = 32'h5555_5555;
      step();
      rst = 0;
      clr();
      m_addr = 0;
      m_val = 0;
      push(0, 5'd0, 0, 0);
      check_out("rstw");
      chk("rstw.ready", in_ready, 1);
      chk("rstw.stall2", stall, 0);
      push(0, 5'd0, 0, 0);
      step();
      check_out("rstw.after");

      one("post.lw", 1, 5'd20, 0, 1, 2'd2, 1, 2'd0, 32'h8765_4321, 1, 32'h8765_4321, 0);
      one("post.alu", 1, 5'd21, 32'h0F0F_0F0F, 0, 0, 0, 0, 0, 1, 32'h0F0F_0F0F, 0);

      d_one("d.lw4", 2'd2, 0, 3'd4, 64'h8000_0001_0000_0000, 1,
            64'hFFFF_FFFF_8000_0001, 0);
      d_one("d.lwu4", 2'd2, 1, 3'd4, 64'h8000_0001_0000_0000, 1,
            64'h0000_0000_8000_0001, 0);
      d_one("d.ld", 2'd3, 1, 3'd0, 64'h8000_0001_0000_0000, 1,
            64'h8000_0001_0000_0000, 0);
      d_one("d.lh6", 2'd1, 0, 3'd6, 64'h8001_0000_0000_0000, 1,
            64'hFFFF_FFFF_FFFF_8001, 0);
      d_one("d.ld.mis", 2'd3, 0, 3'd4, 64'h1, 0, 0, 1);

      chk("sb.drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
